// File: rtl/qdec_ctx_arb.sv
// Context-RAM arbiter for the arithmetic decoder: init writes, SAO/CQT context reads, decoder write-back.
// Optional macro QDEC_CTX_FWD_EN: forwards the write-back context to a same-address read granted in WB.
`timescale 1ns/1ps
module qdec_ctx_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_init_req,
    input  logic [9:0] i_init_addr,
    input  logic [7:0] i_init_wdata,
    output logic       o_init_gnt,
    input  logic       i_sao_req,
    input  logic [9:0] i_sao_addr,
    input  logic       i_cqt_req,
    input  logic [9:0] i_cqt_addr,
    output logic       o_sao_gnt,
    output logic       o_cqt_gnt,
    output logic [9:0] o_mem_addr,
    output logic [7:0] o_mem_wdata,
    output logic       o_mem_we,
    output logic       o_mem_re,
    input  logic [7:0] i_mem_rdata,
    output logic [6:0] o_ctx_state,
    output logic       o_mps,
    output logic       o_ctx_state_vld,
    input  logic       i_ctx_state_rdy,
    input  logic [6:0] i_upd_state,
    input  logic       i_upd_mps,
    input  logic       i_upd_vld,
    output logic       o_upd_rdy,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_PRESENT,
        S_WAIT_UPD,
        S_WB
    } state_t;

    state_t     r_state;
    logic [9:0] r_cur_addr;
    logic [6:0] r_ctx_state;
    logic       r_mps;
    logic [7:0] r_upd;

    logic       w_idle;
    logic       w_wb;
    logic       w_rd_req;
    logic [9:0] w_rd_addr;
    logic       w_init_gnt;
    logic       w_rd_gnt_idle;
    logic       w_fwd_hit;
    logic       w_gnt_any;

    // Init always wins; among reads CQT beats SAO.
    assign w_idle        = (r_state == S_IDLE);
    assign w_wb          = (r_state == S_WB);
    assign w_rd_req      = ~i_init_req & (i_cqt_req | i_sao_req);
    assign w_rd_addr     = i_cqt_req ? i_cqt_addr : i_sao_addr;
    assign w_init_gnt    = w_idle & i_init_req;
    assign w_rd_gnt_idle = w_idle & w_rd_req;

`ifdef QDEC_CTX_FWD_EN
    // Only a same-address read is taken early; a miss waits for IDLE as usual.
    assign w_fwd_hit = w_wb & w_rd_req & (w_rd_addr == r_cur_addr);
`else
    assign w_fwd_hit = 1'b0;
`endif

    assign w_gnt_any = w_rd_gnt_idle | w_fwd_hit;

    assign o_init_gnt = w_init_gnt;
    assign o_cqt_gnt  = w_gnt_any & i_cqt_req;
    assign o_sao_gnt  = w_gnt_any & i_sao_req & ~i_cqt_req;

    assign o_mem_we    = w_init_gnt | w_wb;
    assign o_mem_re    = w_rd_gnt_idle;
    assign o_mem_addr  = w_wb          ? r_cur_addr  :
                         w_init_gnt    ? i_init_addr :
                         w_rd_gnt_idle ? w_rd_addr   : 10'd0;
    assign o_mem_wdata = w_wb       ? r_upd        :
                         w_init_gnt ? i_init_wdata : 8'd0;

    assign o_ctx_state     = r_ctx_state;
    assign o_mps           = r_mps;
    assign o_ctx_state_vld = (r_state == S_PRESENT);
    assign o_upd_rdy       = (r_state == S_WAIT_UPD);
    assign o_busy          = ~w_idle;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= 10'd0;
            r_ctx_state <= 7'd0;
            r_mps       <= 1'b0;
            r_upd       <= 8'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_rd_gnt_idle) begin
                        r_cur_addr <= w_rd_addr;
                        r_state    <= S_RD;
                    end
                end
                S_RD: begin
                    {r_ctx_state, r_mps} <= i_mem_rdata;
                    r_state              <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (i_ctx_state_rdy)
                        r_state <= S_WAIT_UPD;
                end
                S_WAIT_UPD: begin
                    if (i_upd_vld) begin
                        r_upd   <= {i_upd_state, i_upd_mps};
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    if (w_fwd_hit) begin
                        {r_ctx_state, r_mps} <= r_upd;
                        r_state              <= S_PRESENT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
